// File: rtl/i2s_clk_sequencer.sv
// -----------------------------------------------------------------------------
// i2s_clk_sequencer
//
// Master-side clock and frame sequencer for the I2S converters. A single 10-bit
// frame counter running on MCLK generates BCK and LRCK as direct counter bits,
// so both clocks are glitch-free. Divider/frame-length changes are captured
// through a request/busy/ack handshake and applied only at a frame boundary,
// where the counter is 0. After reset, enable and every applied
// reconfiguration, a mute flag is held for MUTE_FRAMES frames.
//
// Ports:
//   i_mclk         master clock, all logic on posedge
//   i_nrst         asynchronous active-low reset
//   i_en           run enable
//   i_cfg_bck_div  requested BCK divider select, BCK = MCLK / 2^(sel+1)
//   i_cfg_frame    requested frame select (0 = 32 BCK/frame, 1 = 64 BCK/frame)
//   i_cfg_req      config request strobe
//   o_cfg_busy     a captured request is waiting for the next frame boundary
//   o_cfg_ack      one-cycle pulse on the first cycle the new config is active
//   o_bck          bit clock
//   o_lrck         word clock, low = left, high = right
//   o_frame_stb    one-cycle pulse on the last MCLK of each frame
//   o_mute         high while output data is invalid
// -----------------------------------------------------------------------------
module i2s_clk_sequencer #(
    parameter int unsigned MUTE_FRAMES = 4,
    parameter logic [1:0]  DEF_BCK_DIV = 2'd0,
    parameter logic        DEF_FRAME   = 1'b1
) (
    input  logic       i_mclk,
    input  logic       i_nrst,
    input  logic       i_en,
    input  logic [1:0] i_cfg_bck_div,
    input  logic       i_cfg_frame,
    input  logic       i_cfg_req,
    output logic       o_cfg_busy,
    output logic       o_cfg_ack,
    output logic       o_bck,
    output logic       o_lrck,
    output logic       o_frame_stb,
    output logic       o_mute
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STOPPING = 2'd2;

    localparam logic [7:0] MUTE_INIT = 8'(MUTE_FRAMES);

    // Registered state
    logic       r_started;
    logic [1:0] r_state;
    logic [9:0] r_cnt;
    logic [1:0] r_sel;
    logic       r_frame;
    logic       r_busy;
    logic [1:0] r_pend_sel;
    logic       r_pend_frame;
    logic       r_ack;
    logic       r_mute;
    logic [7:0] r_mute_cnt;

    // Next-state values
    logic [1:0] w_state_nxt;
    logic [9:0] w_cnt_nxt;
    logic [1:0] w_sel_nxt;
    logic       w_frame_nxt;
    logic       w_busy_nxt;
    logic [1:0] w_pend_sel_nxt;
    logic       w_pend_frame_nxt;
    logic       w_ack_nxt;
    logic       w_mute_nxt;
    logic [7:0] w_mute_cnt_nxt;
    logic       w_mute_dec;

    // Decoded timing
    logic [1:0] w_state;
    logic [3:0] w_shamt;
    logic [3:0] w_bck_idx;
    logic [3:0] w_lr_idx;
    logic [9:0] w_last_cnt;
    logic       w_counting;
    logic       w_last;
    logic       w_wrap;
    logic       w_apply;

    // Until the first clock after reset release the state follows i_en
    // directly, which gives "RUN if enabled, else IDLE" out of reset without
    // an asynchronous load of a non-constant value.
    assign w_state = r_started ? r_state : (i_en ? ST_RUN : ST_IDLE);

    // log2 of the frame length in MCLK cycles: (sel + 1) + 5 + frame.
    assign w_shamt    = {2'b00, r_sel} + 4'd6 + {3'b000, r_frame};
    assign w_last_cnt = 10'h3FF >> (4'd10 - w_shamt);
    assign w_bck_idx  = {2'b00, r_sel};
    // LRCK is the MSB of the frame count, so it toggles once per half frame.
    assign w_lr_idx   = w_shamt - 4'd1;

    assign w_counting = (w_state == ST_RUN) || (w_state == ST_STOPPING);
    assign w_last     = (r_cnt == w_last_cnt);
    assign w_wrap     = w_counting && w_last;

    // A pending config only takes effect when the counter is about to be 0:
    // at a wrap, or at any cycle while idle.
    assign w_apply = r_busy && (w_wrap || (w_state == ST_IDLE));

    always_comb begin
        w_state_nxt      = w_state;
        w_cnt_nxt        = r_cnt;
        w_sel_nxt        = r_sel;
        w_frame_nxt      = r_frame;
        w_busy_nxt       = r_busy;
        w_pend_sel_nxt   = r_pend_sel;
        w_pend_frame_nxt = r_pend_frame;
        w_ack_nxt        = 1'b0;
        w_mute_nxt       = r_mute;
        w_mute_cnt_nxt   = r_mute_cnt;
        w_mute_dec       = 1'b0;

        case (w_state)
            ST_RUN: begin
                w_cnt_nxt = w_last ? 10'd0 : r_cnt + 10'd1;
                if (w_last && !i_en) begin
                    // Enable dropped on the last cycle: this frame is already done.
                    w_state_nxt = ST_IDLE;
                    w_mute_nxt  = 1'b1;
                end else if (w_last) begin
                    w_mute_dec = 1'b1;
                end else if (!i_en) begin
                    w_state_nxt = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                w_cnt_nxt = w_last ? 10'd0 : r_cnt + 10'd1;
                if (i_en) begin
                    // Re-enabled before the frame ended: resume, mute not reloaded.
                    w_state_nxt = ST_RUN;
                    w_mute_dec  = w_last;
                end else if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_mute_nxt  = 1'b1;
                end
            end
            default: begin
                // IDLE, and recovery from the unused encoding.
                w_cnt_nxt  = 10'd0;
                w_mute_nxt = 1'b1;
                if (i_en) begin
                    w_state_nxt    = ST_RUN;
                    w_mute_cnt_nxt = MUTE_INIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase

        if (w_mute_dec && (r_mute_cnt != 8'd0)) begin
            w_mute_cnt_nxt = r_mute_cnt - 8'd1;
            if (r_mute_cnt == 8'd1) begin
                w_mute_nxt = 1'b0;
            end
        end

        // Applying a config restarts the mute window, overriding any decrement.
        if (w_apply) begin
            w_sel_nxt      = r_pend_sel;
            w_frame_nxt    = r_pend_frame;
            w_busy_nxt     = 1'b0;
            w_ack_nxt      = 1'b1;
            w_mute_nxt     = 1'b1;
            w_mute_cnt_nxt = MUTE_INIT;
        end

        // Only an idle handshake captures; requests while busy are dropped so
        // the first captured value wins.
        if (!r_busy && i_cfg_req) begin
            w_busy_nxt       = 1'b1;
            w_pend_sel_nxt   = i_cfg_bck_div;
            w_pend_frame_nxt = i_cfg_frame;
        end
    end

    always_ff @(posedge i_mclk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_started    <= 1'b0;
            r_state      <= ST_IDLE;
            r_cnt        <= 10'd0;
            r_sel        <= DEF_BCK_DIV;
            r_frame      <= DEF_FRAME;
            r_busy       <= 1'b0;
            r_pend_sel   <= DEF_BCK_DIV;
            r_pend_frame <= DEF_FRAME;
            r_ack        <= 1'b0;
            r_mute       <= 1'b1;
            r_mute_cnt   <= MUTE_INIT;
        end else begin
            r_started    <= 1'b1;
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sel        <= w_sel_nxt;
            r_frame      <= w_frame_nxt;
            r_busy       <= w_busy_nxt;
            r_pend_sel   <= w_pend_sel_nxt;
            r_pend_frame <= w_pend_frame_nxt;
            r_ack        <= w_ack_nxt;
            r_mute       <= w_mute_nxt;
            r_mute_cnt   <= w_mute_cnt_nxt;
        end
    end

    // Clock outputs are plain bits of the registered counter; the counter is
    // 0 whenever the select changes, so a switch never produces a runt pulse.
    assign o_bck       = r_cnt[w_bck_idx];
    assign o_lrck      = r_cnt[w_lr_idx];
    // Strobe also marks the final frame while stopping, since it still ends
    // with a wrap.
    assign o_frame_stb = w_wrap;
    assign o_cfg_busy  = r_busy;
    assign o_cfg_ack   = r_ack;
    assign o_mute      = r_mute;

endmodule

// File: tb/tb_i2s_clk_sequencer.sv
module tb_i2s_clk_sequencer;

    logic       clk = 1'b0;
    logic       nrst;
    logic       en;
    logic [1:0] div;
    logic       frm;
    logic       req;
    logic       busy;
    logic       ack;
    logic       bck;
    logic       lrck;
    logic       stb;
    logic       mute;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int ack_base;

    wire [5:0] outs = {bck, lrck, stb, mute, busy, ack};

    always #5 clk = ~clk;

    i2s_clk_sequencer #(
        .MUTE_FRAMES (4),
        .DEF_BCK_DIV (2'd0),
        .DEF_FRAME   (1'b1)
    ) dut (
        .i_mclk        (clk),
        .i_nrst        (nrst),
        .i_en          (en),
        .i_cfg_bck_div (div),
        .i_cfg_frame   (frm),
        .i_cfg_req     (req),
        .o_cfg_busy    (busy),
        .o_cfg_ack     (ack),
        .o_bck         (bck),
        .o_lrck        (lrck),
        .o_frame_stb   (stb),
        .o_mute        (mute)
    );

    // Count acknowledge pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (ack === 1'b1) ack_cnt++;
    end

    typedef struct {
        string      name;
        int         adv;
        logic       en;
        logic       req;
        logic [1:0] div;
        logic       frm;
        logic [5:0] exp_o;   // {bck, lrck, stb, mute, busy, ack}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input int a, input logic e, input logic r,
                                input logic [1:0] d, input logic f, input logic [5:0] x);
        vec_t v;
        v.name  = n;
        v.adv   = a;
        v.en    = e;
        v.req   = r;
        v.div   = d;
        v.frm   = f;
        v.exp_o = x;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_v(input string name, input logic [5:0] act, input logic [5:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b required %b ({bck lrck stb mute busy ack})",
                     name, act, exp_v);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, exp_v);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp_v);
        end
    endtask

    initial begin
        // Defaults: sel=0, frame=1 -> L=128, BCK=cnt[0], LRCK=cnt[6].
        // After the request: sel=2, frame=0 -> L=256, BCK=cnt[2], LRCK=cnt[7].
        // Comment column gives the edge count since reset release.
        vecs.push_back(mk("cnt1",        1, 1, 0, 2'd0, 0, 6'b100100)); // E1
        vecs.push_back(mk("cnt2",        1, 1, 0, 2'd0, 0, 6'b000100)); // E2
        vecs.push_back(mk("cnt63",      61, 1, 0, 2'd0, 0, 6'b100100)); // E63
        vecs.push_back(mk("cnt64",       1, 1, 0, 2'd0, 0, 6'b010100)); // E64
        vecs.push_back(mk("cnt127_stb", 63, 1, 0, 2'd0, 0, 6'b111100)); // E127
        vecs.push_back(mk("wrap1",       1, 1, 0, 2'd0, 0, 6'b000100)); // E128
        vecs.push_back(mk("frame4_last",383, 1, 0, 2'd0, 0, 6'b111100)); // E511
        vecs.push_back(mk("mute_fall",   1, 1, 0, 2'd0, 0, 6'b000000)); // E512
        vecs.push_back(mk("cnt88",      88, 1, 0, 2'd0, 0, 6'b010000)); // E600
        vecs.push_back(mk("req_capture", 1, 1, 1, 2'd2, 0, 6'b110010)); // E601
        vecs.push_back(mk("req_ignored", 1, 1, 1, 2'd3, 1, 6'b010010)); // E602
        vecs.push_back(mk("pend_last",  37, 1, 0, 2'd3, 1, 6'b111010)); // E639
        vecs.push_back(mk("cfg_apply",   1, 1, 0, 2'd3, 1, 6'b000101)); // E640
        vecs.push_back(mk("new_cnt1",    1, 1, 0, 2'd0, 0, 6'b000100)); // E641
        vecs.push_back(mk("new_cnt4",    3, 1, 0, 2'd0, 0, 6'b100100)); // E644
        vecs.push_back(mk("new_cnt128",124, 1, 0, 2'd0, 0, 6'b010100)); // E768
        vecs.push_back(mk("new_last",  127, 1, 0, 2'd0, 0, 6'b111100)); // E895
        vecs.push_back(mk("new_wrap",    1, 1, 0, 2'd0, 0, 6'b000100)); // E896
        vecs.push_back(mk("mute_hold", 767, 1, 0, 2'd0, 0, 6'b111100)); // E1663
        vecs.push_back(mk("mute_fall2",  1, 1, 0, 2'd0, 0, 6'b000000)); // E1664

        nrst = 1'b0;
        en   = 1'b1;
        req  = 1'b0;
        div  = 2'd0;
        frm  = 1'b0;
        #12;
        chk_v("reset_state", outs, 6'b000100);
        #20;
        nrst = 1'b1;   // released away from the clock edge at t=32

        foreach (vecs[i]) begin
            en  = vecs[i].en;
            req = vecs[i].req;
            div = vecs[i].div;
            frm = vecs[i].frm;
            step(vecs[i].adv);
            chk_v(vecs[i].name, outs, vecs[i].exp_o);
        end
        req = 1'b0;
        chk_i("single_ack_first_req", ack_cnt, 1);

        // Request on the strobe cycle: old config (L=256, sel=2) runs one more frame.
        step(255);                                        // E1919, cnt255
        chk_v("stb_cycle", outs, 6'b111000);
        req = 1'b1;
        div = 2'd0;
        frm = 1'b0;
        step(1);                                          // E1920, wrap, not applied
        req = 1'b0;
        chk_v("stb_req_not_applied", outs, 6'b000010);
        step(100);                                        // E2020, old cnt100
        chk_v("old_cfg_mid", outs, 6'b100010);
        step(155);                                        // E2175, old cnt255
        chk_v("old_cfg_last", outs, 6'b111010);
        step(1);                                          // E2176, apply L=64
        chk_v("late_apply", outs, 6'b000101);
        step(1);
        chk_v("l64_cnt1", outs, 6'b100100);
        step(62);                                         // cnt63
        chk_v("l64_last", outs, 6'b111100);
        step(1);
        chk_v("l64_wrap", outs, 6'b000100);
        step(191);                                        // E2431, 4th frame last
        chk_v("l64_mute_hold", outs, 6'b111100);
        step(1);                                          // E2432
        chk_v("l64_mute_fall", outs, 6'b000000);

        // Enable dropped mid-frame: frame completes, then idle.
        step(10);                                         // cnt10
        en = 1'b0;
        step(1);                                          // cnt11, stopping
        chk_b("stop_counting_bck", bck, 1'b1);
        step(52);                                         // cnt63
        chk_b("stop_last_bck", bck, 1'b1);
        chk_b("stop_last_lrck", lrck, 1'b1);
        step(1);
        chk_v("idle_entry", outs, 6'b000100);
        step(5);
        chk_v("idle_hold", outs, 6'b000100);
        en = 1'b1;
        step(1);                                          // E2502, first RUN cycle
        chk_v("rerun_cnt0", outs, 6'b000100);
        step(1);
        chk_v("rerun_cnt1", outs, 6'b100100);
        step(254);                                        // E2757
        chk_v("rerun_mute_hold", outs, 6'b111100);
        step(1);                                          // E2758
        chk_v("rerun_mute_fall", outs, 6'b000000);

        // Switch to L=512 (sel=2, frame=1), then reset at cnt300 with a pending request.
        req = 1'b1;
        div = 2'd2;
        frm = 1'b1;
        step(1);
        req = 1'b0;
        chk_v("l512_req", outs, 6'b100010);
        step(63);                                         // E2822 wrap
        chk_v("l512_apply", outs, 6'b000101);
        step(299);                                        // cnt299
        chk_v("l512_cnt299", outs, 6'b010100);
        req = 1'b1;
        div = 2'd3;
        frm = 1'b0;
        step(1);                                          // cnt300, pending request
        req = 1'b0;
        chk_v("l512_cnt300_busy", outs, 6'b110110);
        #2;
        nrst = 1'b0;
        #1;
        chk_v("async_reset", outs, 6'b000100);
        ack_base = ack_cnt;
        step(2);
        chk_v("reset_hold", outs, 6'b000100);
        nrst = 1'b1;
        step(1);
        chk_v("post_rst_cnt1", outs, 6'b100100);
        step(63);
        chk_v("post_rst_cnt64", outs, 6'b010100);
        step(63);
        chk_v("post_rst_cnt127", outs, 6'b111100);
        step(1);
        chk_v("post_rst_wrap", outs, 6'b000100);
        step(383);
        chk_v("post_rst_mute_hold", outs, 6'b111100);
        step(1);
        chk_v("post_rst_mute_fall", outs, 6'b000000);
        chk_i("post_rst_no_ack", ack_cnt - ack_base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
